// File: rtl/eth_pkg.sv
// Shared constants and types for the receive-path Ethernet address filter.
package eth_pkg;

    localparam logic [7:0]  ETH_SFD   = 8'hD5;
    localparam logic [47:0] ETH_BCAST = 48'hFFFF_FFFF_FFFF;
    localparam int          DA_BYTES  = 6;

    typedef enum logic [1:0] {IDLE, PRE, DA, BODY} eth_state_e;

    // One delay-line slot: tag marks DA-onward bytes, first marks DA byte 0.
    typedef struct packed {
        logic       tag;
        logic       first;
        logic       er;
        logic [7:0] data;
    } dly_stage_t;

endpackage

// File: rtl/eth_dly_line.sv
// LAT-deep byte delay line with per-frame output gate loaded as each frame's first byte exits.
module eth_dly_line
    import eth_pkg::*;
#(
    parameter int LAT = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  dly_stage_t stage_i,
    input  logic       acc_i,
    output logic [7:0] dat_o,
    output logic       dv_o,
    output logic       er_o
);

    dly_stage_t pipe_q [LAT];
    dly_stage_t exit_s;
    logic       gate_q;
    logic       gate_d;
    logic       dv_d;

    // The first byte of a frame picks up the decision; later bytes keep that gate.
    assign exit_s = pipe_q[LAT-1];
    assign gate_d = exit_s.first ? acc_i : gate_q;
    assign dv_d   = exit_s.tag & gate_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
            gate_q <= 1'b0;
            dat_o  <= 8'h00;
            dv_o   <= 1'b0;
            er_o   <= 1'b0;
        end else begin
            pipe_q[0] <= stage_i;
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
            gate_q <= gate_d;
            dv_o   <= dv_d;
            dat_o  <= dv_d ? exit_s.data : 8'h00;
            er_o   <= dv_d & exit_s.er;
        end
    end

endmodule

// File: rtl/eth_addr_filter.sv
// Strips preamble/SFD, filters on destination address and forwards accepted frames after LAT cycles.
// Define ETH_FILT_CNT_EN to build the saturating accepted/dropped frame counters.
module eth_addr_filter
    import eth_pkg::*;
#(
    parameter int N_ADDR = 2,
    parameter int LAT    = 6
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rxdv_i,
    input  logic        rxer_i,
    input  logic [7:0]  rxd_i,
    input  logic        promis_i,
    input  logic        mcast_i,
    input  logic        tbl_we_i,
    input  logic [2:0]  tbl_idx_i,
    input  logic [47:0] tbl_mac_i,
    input  logic        tbl_vld_i,
    output logic [7:0]  dat_o,
    output logic        dv_o,
    output logic        er_o,
    output logic        frm_ok_o,
    output logic        frm_drop_o,
    output logic [15:0] acc_cnt_o,
    output logic [15:0] drp_cnt_o
);

    eth_state_e  state_q, state_d;
    logic [2:0]  cnt_q;
    logic [39:0] da_q;
    logic        da_err_q;
    logic        acc_r;
    logic [47:0] tbl_mac_q [N_ADDR];
    logic        tbl_vld_q [N_ADDR];

    logic        sfd_hit, da_byte, last_da, runt, tbl_hit, accept;
    logic [47:0] da_full;
    dly_stage_t  stage;

    // NOTE: flops use non-blocking assignments so every one samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: each combinational block assigns defaults first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (rxdv_i) state_d = PRE;
            PRE:  if (!rxdv_i) state_d = IDLE;
                  else if (rxd_i == ETH_SFD) state_d = DA;
            DA:   if (!rxdv_i) state_d = IDLE;
                  else if (last_da) state_d = BODY;
            BODY: if (!rxdv_i) state_d = IDLE;
        endcase
    end

    always_comb begin
        sfd_hit     = (state_q == PRE) && rxdv_i && (rxd_i == ETH_SFD);
        da_byte     = (state_q == DA) && rxdv_i;
        last_da     = da_byte && (cnt_q == 3'(DA_BYTES - 1));
        runt        = (state_q == DA) && !rxdv_i;
        stage.tag   = rxdv_i && ((state_q == DA) || (state_q == BODY));
        stage.first = da_byte && (cnt_q == 3'd0);
        stage.er    = rxer_i;
        stage.data  = rxd_i;
    end

    // Decision on the 6th DA byte: the live byte completes the captured address.
    always_comb begin
        da_full = {da_q, rxd_i};
        tbl_hit = 1'b0;
        for (int i = 0; i < N_ADDR; i++)
            if (tbl_vld_q[i] && (tbl_mac_q[i] == da_full)) tbl_hit = 1'b1;
        accept = !(da_err_q || rxer_i) &&
                 (promis_i || (da_full == ETH_BCAST) || (mcast_i && da_full[40]) || tbl_hit);
    end

    // acc_r is read when this frame's first byte exits the delay line, LAT cycles after entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= 3'd0;
            da_q       <= '0;
            da_err_q   <= 1'b0;
            acc_r      <= 1'b0;
            frm_ok_o   <= 1'b0;
            frm_drop_o <= 1'b0;
        end else begin
            frm_ok_o   <= last_da && accept;
            frm_drop_o <= (last_da && !accept) || runt;
            if (sfd_hit) begin
                cnt_q    <= 3'd0;
                da_err_q <= 1'b0;
            end else if (da_byte) begin
                cnt_q    <= cnt_q + 3'd1;
                da_q     <= {da_q[31:0], rxd_i};
                da_err_q <= da_err_q | rxer_i;
            end
            if (last_da)   acc_r <= accept;
            else if (runt) acc_r <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_ADDR; i++) tbl_vld_q[i] <= 1'b0;
        end else begin
            for (int i = 0; i < N_ADDR; i++)
                if (tbl_we_i && (tbl_idx_i == 3'(i))) tbl_vld_q[i] <= tbl_vld_i;
        end
    end

    // NOTE: address storage has no reset; the valid bits alone decide whether an entry is used.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N_ADDR; i++)
            if (tbl_we_i && (tbl_idx_i == 3'(i))) tbl_mac_q[i] <= tbl_mac_i;
    end

`ifdef ETH_FILT_CNT_EN
    logic [15:0] acc_cnt_q, drp_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_cnt_q <= 16'h0000;
            drp_cnt_q <= 16'h0000;
        end else begin
            if (frm_ok_o && (acc_cnt_q != 16'hFFFF))   acc_cnt_q <= acc_cnt_q + 16'd1;
            if (frm_drop_o && (drp_cnt_q != 16'hFFFF)) drp_cnt_q <= drp_cnt_q + 16'd1;
        end
    end

    assign acc_cnt_o = acc_cnt_q;
    assign drp_cnt_o = drp_cnt_q;
`else
    assign acc_cnt_o = 16'h0000;
    assign drp_cnt_o = 16'h0000;
`endif

    eth_dly_line #(.LAT(LAT)) u_dly (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stage_i (stage),
        .acc_i   (acc_r),
        .dat_o   (dat_o),
        .dv_o    (dv_o),
        .er_o    (er_o)
    );

endmodule

// File: tb/tb_eth_addr_filter.sv
// Directed bench for eth_addr_filter: vector table of single frames plus runt, back-to-back,
// reset and counter-saturation sequences.
module tb_eth_addr_filter;

    localparam int N_ADDR = 2;
    localparam int LAT    = 6;
    localparam int NV     = 12;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rxdv_i, rxer_i;
    logic [7:0]  rxd_i;
    logic        promis_i, mcast_i;
    logic        tbl_we_i;
    logic [2:0]  tbl_idx_i;
    logic [47:0] tbl_mac_i;
    logic        tbl_vld_i;
    logic [7:0]  dat_o;
    logic        dv_o, er_o, frm_ok_o, frm_drop_o;
    logic [15:0] acc_cnt_o, drp_cnt_o;

    always #5 clk_i = ~clk_i;

    eth_addr_filter #(.N_ADDR(N_ADDR), .LAT(LAT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rxdv_i(rxdv_i), .rxer_i(rxer_i), .rxd_i(rxd_i),
        .promis_i(promis_i), .mcast_i(mcast_i), .tbl_we_i(tbl_we_i), .tbl_idx_i(tbl_idx_i),
        .tbl_mac_i(tbl_mac_i), .tbl_vld_i(tbl_vld_i), .dat_o(dat_o), .dv_o(dv_o), .er_o(er_o),
        .frm_ok_o(frm_ok_o), .frm_drop_o(frm_drop_o), .acc_cnt_o(acc_cnt_o), .drp_cnt_o(drp_cnt_o)
    );

    typedef struct {
        string       name;
        logic [47:0] da;
        logic        promis;
        logic        mcast;
        int          er_idx;
        logic        acc;
    } vec_t;

    vec_t       vecs [NV];
    int         n_tests = 0, n_fail = 0;
    int         cyc = 0, da_cyc = 0;
    int         tot_acc = 0, tot_drp = 0;
    logic [7:0] exp_q [$];
    int         exp_er = 0;

    // Output monitor, sampled on the falling edge.
    logic [7:0] out_q [$];
    int         dv_first = -1, dv_last = -1, ok_cnt = 0, drop_cnt = 0, both_cnt = 0;
    int         er_cnt = 0, stray = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (dv_o) begin
            out_q.push_back(dat_o);
            if (dv_first < 0) dv_first = cyc;
            dv_last = cyc;
            if (er_o) er_cnt++;
        end else if ((dat_o != 8'h00) || er_o) begin
            stray++;
        end
        if (frm_ok_o) ok_cnt++;
        if (frm_drop_o) drop_cnt++;
        if (frm_ok_o && frm_drop_o) both_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic [7:0] d, input logic er);
        rxdv_i = dv;
        rxd_i  = d;
        rxer_i = er;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic tbl_write(input logic [2:0] idx, input logic [47:0] mac, input logic vld);
        tbl_we_i  = 1'b1;
        tbl_idx_i = idx;
        tbl_mac_i = mac;
        tbl_vld_i = vld;
        @(posedge clk_i);
        #1;
        tbl_we_i = 1'b0;
    endtask

    task automatic clear_mon();
        out_q.delete();
        exp_q.delete();
        exp_er   = 0;
        dv_first = -1;
        dv_last  = -1;
        ok_cnt   = 0;
        drop_cnt = 0;
        both_cnt = 0;
        er_cnt   = 0;
        stray    = 0;
    endtask

    task automatic preamble();
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
    endtask

    // Full frame: preamble, SFD, DA, plen payload bytes, then one idle cycle.
    task automatic send_frame(input logic [47:0] da, input int plen, input logic acc, input int er_idx);
        logic [7:0] b;
        logic       e;
        preamble();
        da_cyc = cyc;
        for (int k = 0; k < 6 + plen; k++) begin
            b = (k < 6) ? da[47-8*k -: 8] : 8'(k * 29 + 13);
            e = (k == er_idx);
            drive(1'b1, b, e);
            if (acc) begin
                exp_q.push_back(b);
                if (e) exp_er++;
            end
        end
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_cnt(input string name);
`ifdef ETH_FILT_CNT_EN
        check({name, "_acc_cnt"}, 64'(acc_cnt_o), 64'(tot_acc));
        check({name, "_drp_cnt"}, 64'(drp_cnt_o), 64'(tot_drp));
`else
        check({name, "_acc_cnt"}, 64'(acc_cnt_o), 64'd0);
        check({name, "_drp_cnt"}, 64'(drp_cnt_o), 64'd0);
`endif
    endtask

    task automatic check_frame(input string name, input int n_ok, input int n_drop, input logic timing);
        int bad;
        check({name, "_ok"}, 64'(ok_cnt), 64'(n_ok));
        check({name, "_drop"}, 64'(drop_cnt), 64'(n_drop));
        check({name, "_both"}, 64'(both_cnt), 64'd0);
        check({name, "_nbytes"}, 64'(out_q.size()), 64'(exp_q.size()));
        bad = 0;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            if (out_q[i] !== exp_q[i]) bad++;
        check({name, "_data"}, 64'(bad), 64'd0);
        check({name, "_er"}, 64'(er_cnt), 64'(exp_er));
        check({name, "_stray"}, 64'(stray), 64'd0);
        if (timing && (exp_q.size() > 0)) begin
            check({name, "_first"}, 64'(dv_first), 64'(da_cyc + 1 + LAT));
            check({name, "_span"}, 64'(dv_last - dv_first + 1), 64'(exp_q.size()));
        end
        tot_acc = (tot_acc + n_ok > 65535) ? 65535 : tot_acc + n_ok;
        tot_drp = (tot_drp + n_drop > 65535) ? 65535 : tot_drp + n_drop;
        check_cnt(name);
    endtask

    initial begin
        vecs[0]  = '{"uc_hit",   48'h0200_0000_0001, 1'b0, 1'b0, -1, 1'b1};
        vecs[1]  = '{"uc_miss",  48'h0200_0000_0002, 1'b0, 1'b0, -1, 1'b0};
        vecs[2]  = '{"mc_off",   48'h0100_5E00_0001, 1'b0, 1'b0, -1, 1'b0};
        vecs[3]  = '{"mc_on",    48'h0100_5E00_0001, 1'b0, 1'b1, -1, 1'b1};
        vecs[4]  = '{"bcast",    48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, -1, 1'b1};
        vecs[5]  = '{"promis",   48'h0200_0000_0002, 1'b1, 1'b0, -1, 1'b1};
        vecs[6]  = '{"tbl_inv",  48'h0A0B_0C0D_0E0F, 1'b0, 1'b0, -1, 1'b0};
        vecs[7]  = '{"tbl_oob",  48'h0606_0606_0606, 1'b0, 1'b0, -1, 1'b0};
        vecs[8]  = '{"da_err",   48'h0200_0000_0001, 1'b1, 1'b0,  2, 1'b0};
        vecs[9]  = '{"last_err", 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0,  5, 1'b0};
        vecs[10] = '{"pl_err",   48'h0200_0000_0001, 1'b0, 1'b0, 20, 1'b1};
        vecs[11] = '{"mc_uni",   48'h0200_0000_0003, 1'b0, 1'b1, -1, 1'b0};

        rst_i = 1'b1; rxdv_i = 1'b0; rxer_i = 1'b0; rxd_i = 8'h00;
        promis_i = 1'b0; mcast_i = 1'b0;
        tbl_we_i = 1'b0; tbl_idx_i = 3'd0; tbl_mac_i = '0; tbl_vld_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_dv", 64'(dv_o), 64'd0);
        check("rst_dat", 64'(dat_o), 64'd0);
        check("rst_ok", 64'(frm_ok_o), 64'd0);
        check("rst_drop", 64'(frm_drop_o), 64'd0);
        check_cnt("rst");
        rst_i = 1'b0;
        idle(2);

        tbl_write(3'd0, 48'h0200_0000_0001, 1'b1);
        tbl_write(3'd1, 48'h0A0B_0C0D_0E0F, 1'b0);
        tbl_write(3'd5, 48'h0606_0606_0606, 1'b1);

        for (int v = 0; v < NV; v++) begin
            promis_i = vecs[v].promis;
            mcast_i  = vecs[v].mcast;
            clear_mon();
            send_frame(vecs[v].da, 50, vecs[v].acc, vecs[v].er_idx);
            idle(LAT + 4);
            check_frame(vecs[v].name, vecs[v].acc ? 1 : 0, vecs[v].acc ? 0 : 1, 1'b1);
        end
        promis_i = 1'b0;
        mcast_i  = 1'b0;

        // Runt after 3 DA bytes, then a matching frame after one idle cycle.
        clear_mon();
        preamble();
        drive(1'b1, 8'h02, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        send_frame(48'h0200_0000_0001, 50, 1'b1, -1);
        idle(LAT + 4);
        check_frame("runt", 1, 1, 1'b1);

        // Accepted then rejected with a one-cycle gap: only frame 1 is forwarded.
        clear_mon();
        send_frame(48'h0200_0000_0001, 50, 1'b1, -1);
        send_frame(48'h0200_0000_0002, 50, 1'b0, -1);
        idle(LAT + 4);
        check_frame("b2b_acc_rej", 1, 1, 1'b0);

        // Rejected then accepted with a one-cycle gap.
        clear_mon();
        send_frame(48'h0200_0000_0002, 30, 1'b0, -1);
        send_frame(48'h0200_0000_0001, 30, 1'b1, -1);
        idle(LAT + 4);
        check_frame("b2b_rej_acc", 1, 1, 1'b1);

        // Reset in the middle of an accepted frame's body.
        clear_mon();
        preamble();
        for (int k = 0; k < 6; k++) drive(1'b1, (k == 5) ? 8'h01 : ((k == 0) ? 8'h02 : 8'h00), 1'b0);
        for (int k = 0; k < 20; k++) drive(1'b1, 8'(k + 1), 1'b0);
        check("midrst_dv_before", 64'(dv_o), 64'd1);
        rst_i  = 1'b1;
        rxdv_i = 1'b0;
        #1;
        check("midrst_dv", 64'(dv_o), 64'd0);
        check("midrst_dat", 64'(dat_o), 64'd0);
        tot_acc = 0;
        tot_drp = 0;
        check_cnt("midrst");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle(2);
        clear_mon();
        send_frame(48'h0200_0000_0001, 20, 1'b0, -1);
        idle(LAT + 4);
        check_frame("post_rst_tbl", 0, 1, 1'b0);

        // Counter saturation.
        tbl_write(3'd0, 48'h0200_0000_0001, 1'b1);
`ifdef ETH_FILT_CNT_EN
        force dut.acc_cnt_q = 16'hFFFE;
        @(posedge clk_i);
        #1;
        release dut.acc_cnt_q;
        tot_acc = 65534;
`endif
        for (int f = 0; f < 3; f++) begin
            clear_mon();
            send_frame(48'h0200_0000_0001, 10, 1'b1, -1);
            idle(LAT + 4);
            check_frame("sat", 1, 0, 1'b1);
        end
`ifdef ETH_FILT_CNT_EN
        check("sat_final", 64'(acc_cnt_o), 64'h0000_0000_0000_FFFF);
`else
        check("sat_final", 64'(acc_cnt_o), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
